// File: rtl/wave_pkg.sv
// Shared constants for the wave RAM sequencer: state encoding and default widths.
// No logic, no latency.
// No flow control.
package wave_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 9;
  localparam int DIV_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

endpackage

// File: rtl/wave_tick_div.sv
// Playback divider: one tick every div+1 enabled cycles, first tick on the first enabled cycle.
// Tick is combinational from the count register and the live div value.
// No backpressure; enable gates counting, clear re-arms the immediate first tick.
module wave_tick_div
  import wave_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;
  logic             armed;

  // Armed forces the tick on the first enabled cycle. >= keeps a lowered div from
  // letting the count run past it and wrap the whole counter range.
  assign tick = enable && (armed || (count >= div));

  // Count 0..div while enabled; reload 0 after each tick.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      armed <= 1'b1;
    end else if (clear) begin
      count <= '0;
      armed <= 1'b1;
    end else if (tick) begin
      count <= '0;
      armed <= 1'b0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wave_ram_seq.sv
// Wave RAM sequencer: loads samples into an external RAM, then plays them back at a divided rate.
// RAM writes are combinational from the handshake; sample appears two cycles after its tick.
// wr_ready is high only while loading; playback has no backpressure.
module wave_ram_seq
  import wave_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_last,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              play_en,
  input  logic [DIV_W-1:0]  div,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] sample,
  output logic              sample_v,
  output logic              loaded,
  output logic [1:0]        state_o
);

  logic              rst_meta;
  logic              rst_sync_n;
  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] last;
  logic              rd_pend;
  logic              tick;
  logic              wr_fire;
  logic              wr_done;

  assign wr_fire = (state == ST_LOAD) && wr_valid;
  assign wr_done = wr_fire && (wr_ptr == load_last);
  assign state_o = state;

  // Two-flop reset synchroniser: assert immediately, release on the second edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // Divider runs only in PLAY and is held cleared elsewhere, so entry ticks at once.
  wave_tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .sys_clk (sys_clk),
    .rst_n   (rst_sync_n),
    .enable  (state == ST_PLAY),
    .clear   (state != ST_PLAY),
    .div     (div),
    .tick    (tick)
  );

  // State register.
  always_ff @(posedge sys_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic; load_start overrides everything, including play_en.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (play_en && loaded) state_nxt = ST_PLAY;
      ST_LOAD: if (wr_done)           state_nxt = ST_IDLE;
      ST_PLAY: if (!play_en)          state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
    if (load_start) state_nxt = ST_LOAD;
  end

  // RAM port and handshake outputs: write pointer while loading, read pointer while playing.
  always_comb begin
    wr_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      ST_LOAD: begin
        wr_ready  = 1'b1;
        ram_we    = wr_fire;
        ram_addr  = wr_ptr;
        ram_wdata = wr_fire ? wr_data : '0;
      end
      ST_PLAY: ram_addr = rd_ptr;
      default: ram_addr = '0;
    endcase
  end

  // Write pointer and load bookkeeping; a new load_start restarts from address 0.
  always_ff @(posedge sys_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wr_ptr <= '0;
      loaded <= 1'b0;
      last   <= '0;
    end else if (load_start) begin
      wr_ptr <= '0;
      loaded <= 1'b0;
    end else if (wr_done) begin
      wr_ptr <= '0;
      loaded <= 1'b1;
      last   <= load_last;
    end else if (wr_fire) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Read pointer advances per tick, wraps at last, and sits at 0 outside PLAY.
  always_ff @(posedge sys_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      rd_ptr <= '0;
    end else if (state != ST_PLAY) begin
      rd_ptr <= '0;
    end else if (tick) begin
      rd_ptr <= (rd_ptr == last) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Capture read data one cycle after the tick; runs in any state so an exit-cycle read completes.
  always_ff @(posedge sys_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      rd_pend  <= 1'b0;
      sample_v <= 1'b0;
      sample   <= '0;
    end else begin
      rd_pend  <= tick;
      sample_v <= rd_pend;
      if (rd_pend) sample <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_wave_ram_seq.sv
// Directed bench for wave_ram_seq with a synchronous one-cycle-latency RAM model.
// Inputs are driven 2 time units after the rising edge, outputs checked 1 unit later.
// Summary line reports assertions evaluated and failures.
module tb_wave_ram_seq;

  localparam int AW = 8;
  localparam int DW = 9;
  localparam int VW = 16;

  logic          sys_clk;
  logic          rst_n;
  logic          load_start;
  logic [AW-1:0] load_last;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          play_en;
  logic [VW-1:0] div;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] sample;
  logic          sample_v;
  logic          loaded;
  logic [1:0]    state_o;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int n_chk;
  int n_fail;
  int exp_seq [5];

  wave_ram_seq #(.ADDR_W(AW), .DATA_W(DW), .DIV_W(VW)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_last  (load_last),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .play_en    (play_en),
    .div        (div),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .sample     (sample),
    .sample_v   (sample_v),
    .loaded     (loaded),
    .state_o    (state_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Synchronous RAM: read data valid one cycle after the address.
  always @(posedge sys_clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge sys_clk);
    #2;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_seq = '{10, 11, 12, 13, 10};
    rst_n = 1'b0; load_start = 1'b0; load_last = '0; wr_valid = 1'b0;
    wr_data = '0; play_en = 1'b0; div = '0;

    // Reset values, with inputs that would otherwise provoke activity.
    repeat (3) @(posedge sys_clk);
    #2;
    wr_valid = 1'b1; play_en = 1'b1;
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_sample", sample, 0);
    chk("rst_sample_v", sample_v, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    wr_valid = 1'b0; play_en = 1'b0;
    rst_n = 1'b1;
    repeat (3) nxt();

    // Load last=3, samples 10..13, wr_valid gapped every other cycle.
    load_last = 8'd3; load_start = 1'b1;
    nxt();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = DW'(10 + i);
      #1;
      chk("ld_state", state_o, 1);
      chk("ld_wr_ready", wr_ready, 1);
      chk("ld_ram_we", ram_we, 1);
      chk("ld_ram_addr", ram_addr, i);
      chk("ld_ram_wdata", ram_wdata, 10 + i);
      chk("ld_loaded_low", loaded, 0);
      nxt();
      wr_valid = 1'b0;
      #1;
      chk("ld_gap_we", ram_we, 0);
      if (i < 3) chk("ld_gap_state", state_o, 1);
      else begin
        chk("ld_done_state", state_o, 0);
        chk("ld_done_loaded", loaded, 1);
      end
      nxt();
    end

    // Playback div=2: sample_v every third cycle, 10,11,12,13,10.
    div = 16'd2; play_en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      nxt();
      #1;
      if (k == 0) begin
        chk("pl_state", state_o, 2);
        chk("pl_first_addr", ram_addr, 0);
      end
      if (k >= 2 && ((k - 2) % 3) == 0) begin
        chk("pl_sample_v", sample_v, 1);
        chk("pl_sample", sample, exp_seq[(k - 2) / 3]);
      end else begin
        chk("pl_sample_v_idle", sample_v, 0);
      end
    end
    play_en = 1'b0;
    nxt();
    #1;
    chk("pl_exit_state", state_o, 0);
    chk("pl_exit_hold", sample, 10);
    chk("pl_exit_v", sample_v, 0);

    // Load last=0 with one sample, then div=0 playback.
    load_last = 8'd0; load_start = 1'b1;
    nxt();
    load_start = 1'b0; wr_valid = 1'b1; wr_data = 9'd77;
    #1;
    chk("l0_we", ram_we, 1);
    chk("l0_addr", ram_addr, 0);
    nxt();
    wr_valid = 1'b0;
    #1;
    chk("l0_state", state_o, 0);
    chk("l0_loaded", loaded, 1);
    div = 16'd0; play_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      nxt();
      #1;
      chk("d0_addr", ram_addr, 0);
      if (k < 2) chk("d0_v_early", sample_v, 0);
      else begin
        chk("d0_v", sample_v, 1);
        chk("d0_sample", sample, 77);
      end
    end
    // Drop play_en during a ticking cycle: that read must still deliver.
    play_en = 1'b0;
    nxt();
    #1;
    chk("d0_x1_state", state_o, 0);
    chk("d0_x1_v", sample_v, 1);
    nxt();
    #1;
    chk("d0_x2_v_exit_read", sample_v, 1);
    nxt();
    #1;
    chk("d0_x3_v", sample_v, 0);
    chk("d0_x3_hold", sample, 77);

    // load_start in the middle of PLAY.
    div = 16'd1; play_en = 1'b1;
    nxt();
    nxt();
    #1;
    chk("mp_state_play", state_o, 2);
    load_start = 1'b1; load_last = 8'd3;
    nxt();
    load_start = 1'b0;
    #1;
    chk("mp_state_load", state_o, 1);
    chk("mp_loaded", loaded, 0);
    chk("mp_no_we", ram_we, 0);
    chk("mp_wr_ready", wr_ready, 1);
    nxt();
    #1;
    chk("mp_no_we2", ram_we, 0);
    chk("mp_play_ignored", state_o, 1);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = DW'(20 + i);
      #1;
      chk("mp_we", ram_we, 1);
      chk("mp_addr", ram_addr, i);
      nxt();
    end
    wr_valid = 1'b0; play_en = 1'b0;
    #1;
    chk("mp_done_state", state_o, 0);
    chk("mp_done_loaded", loaded, 1);

    // Reset after 2 of 4 writes.
    nxt();
    load_last = 8'd3; load_start = 1'b1;
    nxt();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1; wr_data = DW'(30 + i);
      nxt();
    end
    rst_n = 1'b0;
    #1;
    chk("mr_state", state_o, 0);
    chk("mr_loaded", loaded, 0);
    chk("mr_sample", sample, 0);
    chk("mr_sample_v", sample_v, 0);
    chk("mr_wr_ready", wr_ready, 0);
    chk("mr_ram_we", ram_we, 0);
    wr_valid = 1'b0;
    nxt();
    rst_n = 1'b1; play_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      nxt();
      #1;
      chk("mr_play_blocked", state_o, 0);
    end
    load_last = 8'd1; load_start = 1'b1;
    nxt();
    load_start = 1'b0;
    #1;
    chk("rl_state", state_o, 1);
    wr_valid = 1'b1; wr_data = 9'd40;
    #1;
    chk("rl_addr0", ram_addr, 0);
    nxt();
    wr_data = 9'd41;
    #1;
    chk("rl_addr1", ram_addr, 1);
    chk("rl_we1", ram_we, 1);
    nxt();
    wr_valid = 1'b0;
    #1;
    chk("rl_done_state", state_o, 0);
    chk("rl_done_loaded", loaded, 1);
    nxt();
    #1;
    chk("rl_play_state", state_o, 2);
    chk("rl_play_addr", ram_addr, 0);
    play_en = 1'b0;
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
